// File: rtl/cont_seq_ctrl_pkg.sv
// cont_seq_ctrl_pkg: mode encodings, FSM states and Gray-next table shared by the sequence controller
package cont_seq_ctrl_pkg;
  localparam logic [2:0] MODE_UP   = 3'd0;
  localparam logic [2:0] MODE_DOWN = 3'd1;
  localparam logic [2:0] MODE_GRAY = 3'd2;
  localparam logic [2:0] MODE_JOHN = 3'd3;
  localparam logic [2:0] MODE_RING = 3'd4;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;
  // indexed by q[2:0]: 0->1->3->2->6->7->5->0, unused code 4 falls back to 0
  localparam logic [7:0][3:0] GRAY_NXT = {4'd5, 4'd7, 4'd0, 4'd0, 4'd2, 4'd6, 4'd3, 4'd1};
  function automatic logic mode_legal(logic [2:0] m);
    return m <= MODE_RING;
  endfunction
endpackage

// File: rtl/cont_seq_ctrl_if.sv
// cont_seq_ctrl_if: control/status bundle between a run requester and the sequence controller
interface cont_seq_ctrl_if;
  logic       start, stop, step;
  logic [2:0] mode;
  logic [3:0] len, init, q;
  logic       busy, done, tc, err;
  modport master (output start, stop, step, mode, len, init, input q, busy, done, tc, err);
  modport slave  (input start, stop, step, mode, len, init, output q, busy, done, tc, err);
endinterface

// File: rtl/cont_next_val.sv
// cont_next_val: next counter value and terminal-count flag for the selected sequence
module cont_next_val
  import cont_seq_ctrl_pkg::*;
#(
  parameter int MOD_N = 8
) (
  input  logic [2:0] mode_i,
  input  logic [3:0] q_i,
  output logic [3:0] nxt_o,
  output logic       tc_o
);
  localparam logic [3:0] TOP = 4'(MOD_N - 1);
  always_comb begin
    nxt_o = q_i;
    tc_o  = 1'b0;
    case (mode_i)
      MODE_UP: begin
        nxt_o = (q_i == TOP) ? 4'd0 : q_i + 4'd1;
        tc_o  = q_i == TOP;
      end
      MODE_DOWN: begin
        nxt_o = (q_i == 4'd0) ? TOP : q_i - 4'd1;
        tc_o  = q_i == 4'd0;
      end
      MODE_GRAY: begin
        nxt_o = GRAY_NXT[q_i[2:0]];
        tc_o  = q_i == 4'd5;
      end
      MODE_JOHN: begin
        nxt_o = {~q_i[0], q_i[3:1]};
        tc_o  = q_i == 4'b0001;
      end
      MODE_RING: begin
        nxt_o = {q_i[0], q_i[3:1]};
        tc_o  = q_i == 4'b0001;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/cont_seq_ctrl.sv
// cont_seq_ctrl: run controller stepping a 4-bit counter through up/down/Gray/Johnson/ring sequences
module cont_seq_ctrl
  import cont_seq_ctrl_pkg::*;
#(
  parameter int MOD_N = 8
) (
  input  logic          ck,
  input  logic          clr,
  cont_seq_ctrl_if.slave bus
);
  state_e     state_q, state_d;
  logic [3:0] q_q, q_d, rem_q, rem_d, len_q, len_d, init_q, init_d, nxt, seed;
  logic [2:0] mode_q, mode_d;
  logic       err_q, err_d, tc;
  cont_next_val #(.MOD_N(MOD_N)) u_next (.mode_i(mode_q), .q_i(q_q), .nxt_o(nxt), .tc_o(tc));
  // seed uses the init captured at accept so later init changes cannot leak in
  always_comb
    seed = (mode_q == MODE_UP || mode_q == MODE_DOWN) ? ((int'(init_q) < MOD_N) ? init_q : 4'd0) :
           (mode_q == MODE_RING) ? ((init_q == 4'd0) ? 4'd1 : init_q) : 4'd0;
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    len_d   = len_q;
    init_d  = init_q;
    err_d   = err_q;
    case (state_q)
      IDLE:
        if (bus.start) begin
          if (mode_legal(bus.mode)) begin
            state_d = LOAD;
            mode_d  = bus.mode;
            len_d   = bus.len;
            init_d  = bus.init;
          end else err_d = 1'b1;
        end
      LOAD:
        if (bus.stop) state_d = IDLE;
        else begin
          q_d     = seed;
          rem_d   = len_q;
          state_d = (len_q == 4'd0) ? DONE : RUN;
        end
      RUN:
        if (bus.stop) state_d = IDLE;
        else if (bus.step) begin
          q_d   = nxt;
          rem_d = rem_q - 4'd1;
          if (rem_q == 4'd1) state_d = DONE;
        end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge ck or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      q_q     <= 4'd0;
      rem_q   <= 4'd0;
      mode_q  <= MODE_UP;
      len_q   <= 4'd0;
      init_q  <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
      init_q  <= init_d;
      err_q   <= err_d;
    end
  end
  assign bus.q    = q_q;
  assign bus.busy = (state_q == LOAD) || (state_q == RUN);
  assign bus.done = state_q == DONE;
  assign bus.tc   = tc;
  assign bus.err  = err_q;
endmodule
